msgdecode: RTL and testbench

- Receive-side frame parser for the host serial link. Consumes the framed byte stream the host sends: header, sequence, word count, 4*count data bytes (little-endian words), CRC16-CCITT high/low, then terminator 0x7e.
- Emits 32-bit command words tagged with stream id and sequence. Reports end-of-message status so consumers commit or discard the words.
- Sits between the UART rx byte stage and the command dispatch logic.

---
 rtl/msgdecode_pkg.sv | 36 +++
 rtl/msgdecode_if.sv | 34 +++
 rtl/msgdecode_crc.sv | 23 ++
 rtl/msgdecode.sv | 179 +++++++++++++++++
 tb/tb_msgdecode.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/msgdecode_pkg.sv
// Shared definitions for the host-link framing: parser states, framing
// constants and the CRC16-CCITT byte update used by the CRC engine.
package msgdecode_pkg;

    localparam logic [3:0]  HDR_NIBBLE = 4'b0110;  // required upper nibble of header
    localparam logic [7:0]  SYNC_CHAR  = 8'h7e;    // terminator and idle fill
    localparam logic [15:0] CRC_INIT   = 16'h0000; // value the CRC is cleared to
    localparam logic [15:0] CRC_POLY   = 16'h1021; // x^16 + x^12 + x^5 + 1

    typedef enum logic [3:0] {
        HUNT  = 4'd0,
        HDR   = 4'd1,
        SEQ   = 4'd2,
        COUNT = 4'd3,
        DATA0 = 4'd4,
        DATA1 = 4'd5,
        DATA2 = 4'd6,
        DATA3 = 4'd7,
        CRC0  = 4'd8,
        CRC1  = 4'd9,
        TERM  = 4'd10
    } state_t;

    // MSB-first CRC16-CCITT update over one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = (c << 1) ^ CRC_POLY;
            else                 c = c << 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/msgdecode_if.sv
// Byte-in / word-out bundle between the UART rx stage, the frame parser and
// command dispatch. Optional seq_err member follows MSGDECODE_SEQCHECK_EN.
//
// Handshake: every *_avail / msg_done is a one-cycle strobe qualifying its
// data in that same cycle; there is no ready/backpressure, so the receiver
// must accept every strobe, and strobes may occur on consecutive cycles.
interface msgdecode_if;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic [31:0] out_data;
    logic        out_avail;
    logic [3:0]  out_id;
    logic [5:0]  out_seq;
    logic        msg_done;
    logic        msg_ok;
    logic [7:0]  err_count;
`ifdef MSGDECODE_SEQCHECK_EN
    logic        seq_err;

    modport master (output rx_data, rx_avail,
                    input  out_data, out_avail, out_id, out_seq,
                           msg_done, msg_ok, err_count, seq_err);
    modport slave  (input  rx_data, rx_avail,
                    output out_data, out_avail, out_id, out_seq,
                           msg_done, msg_ok, err_count, seq_err);
`else
    modport master (output rx_data, rx_avail,
                    input  out_data, out_avail, out_id, out_seq,
                           msg_done, msg_ok, err_count);
    modport slave  (input  rx_data, rx_avail,
                    output out_data, out_avail, out_id, out_seq,
                           msg_done, msg_ok, err_count);
`endif
endinterface

// File: rtl/msgdecode_crc.sv
// CRC16-CCITT accumulator: clears on 'clear', folds in 'data' on 'avail'.
// The running value is visible one cycle after each fed byte.
module crc16ccitt
    import msgdecode_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  data,
    input  logic        avail,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    // Clear wins so that a reset cycle always leaves the engine at init.
    always_ff @(posedge clk) begin
        if (clear)      r_crc <= CRC_INIT;
        else if (avail) r_crc <= crc16_byte(r_crc, data);
    end

    assign crc = r_crc;

endmodule

// File: rtl/msgdecode.sv
// Receive-side frame parser: header, seq, count, 4*count LE data bytes,
// CRC hi/lo, terminator. Emits tagged 32-bit words and end-of-message status.
// Optional sequence tracking (seq_err output) under MSGDECODE_SEQCHECK_EN.
module msgdecode
    import msgdecode_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    msgdecode_if.slave    io_bus,
    output state_t        o_dbg_state
);

    state_t      r_state, w_next;
    logic [7:0]  w_rx_data;
    logic        w_rx_avail;
    logic        w_hdr_ok, w_done, w_ok, w_frame_err;
    logic        w_crc_clear, w_crc_avail;
    logic [15:0] w_crc;

    logic [3:0]  r_id;
    logic [5:0]  r_seq;
    logic [7:0]  r_count;
    logic [23:0] r_word;
    logic        r_crc_bad;
    logic [31:0] r_out_data;
    logic        r_out_avail;
    logic        r_msg_done;
    logic        r_msg_ok;
    logic [7:0]  r_err_count;

    assign w_rx_data  = io_bus.rx_data;
    assign w_rx_avail = io_bus.rx_avail;
    assign w_hdr_ok   = w_rx_avail && (r_state == HDR) && (w_rx_data != SYNC_CHAR)
                        && (w_rx_data[7:4] == HDR_NIBBLE);

    // Clearing also in TERM keeps a header that arrives right after the
    // terminator from starting on the previous message's CRC.
    assign w_crc_clear = rst || (r_state == HUNT) || (r_state == TERM)
                         || ((r_state == HDR) && !w_hdr_ok);
    assign w_crc_avail = !rst && (w_hdr_ok || (w_rx_avail &&
                         (r_state inside {SEQ, COUNT, DATA0, DATA1, DATA2, DATA3})));

    crc16ccitt u_crc (
        .clk   (clk),
        .clear (w_crc_clear),
        .data  (w_rx_data),
        .avail (w_crc_avail),
        .crc   (w_crc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= HDR;
        else     r_state <= w_next;
    end

    // Next state plus message-end and framing-error decisions for this byte.
    always_comb begin
        w_next      = r_state;
        w_done      = 1'b0;
        w_ok        = 1'b0;
        w_frame_err = 1'b0;
        if (w_rx_avail) begin
            case (r_state)
                HUNT:  if (w_rx_data == SYNC_CHAR) w_next = HDR;
                HDR: begin
                    if (w_hdr_ok) w_next = SEQ;
                    else if (w_rx_data != SYNC_CHAR) begin
                        w_frame_err = 1'b1;
                        w_next      = HUNT;
                    end
                end
                SEQ: begin
                    if (w_rx_data[7:6] == 2'b00) w_next = COUNT;
                    else begin
                        w_done = 1'b1;
                        w_next = HUNT;
                    end
                end
                COUNT: w_next = (w_rx_data == 8'd0) ? CRC0 : DATA0;
                DATA0: w_next = DATA1;
                DATA1: w_next = DATA2;
                DATA2: w_next = DATA3;
                DATA3: w_next = (r_count == 8'd1) ? CRC0 : DATA0;
                CRC0:  w_next = CRC1;
                CRC1:  w_next = TERM;
                TERM: begin
                    w_done = 1'b1;
                    if (w_rx_data == SYNC_CHAR) begin
                        w_ok   = !r_crc_bad;
                        w_next = HDR;
                    end else begin
                        w_next = HUNT;
                    end
                end
                default: w_next = HUNT;
            endcase
        end
    end

    // Field capture, word assembly, CRC compare and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id        <= '0;
            r_seq       <= '0;
            r_count     <= '0;
            r_word      <= '0;
            r_crc_bad   <= 1'b0;
            r_out_data  <= '0;
            r_out_avail <= 1'b0;
            r_msg_done  <= 1'b0;
            r_msg_ok    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_out_avail <= 1'b0;
            r_msg_done  <= w_done;
            r_msg_ok    <= w_ok;
            if (w_rx_avail) begin
                case (r_state)
                    HDR:   if (w_hdr_ok) r_id <= w_rx_data[3:0];
                    SEQ:   if (w_rx_data[7:6] == 2'b00) r_seq <= w_rx_data[5:0];
                    COUNT: begin
                        r_count   <= w_rx_data;
                        r_crc_bad <= 1'b0;
                    end
                    DATA0: r_word[7:0]   <= w_rx_data;
                    DATA1: r_word[15:8]  <= w_rx_data;
                    DATA2: r_word[23:16] <= w_rx_data;
                    DATA3: begin
                        r_out_data  <= {w_rx_data, r_word};
                        r_out_avail <= 1'b1;
                        r_count     <= r_count - 8'd1;
                    end
                    CRC0:  if (w_rx_data != w_crc[15:8]) r_crc_bad <= 1'b1;
                    CRC1:  if (w_rx_data != w_crc[7:0])  r_crc_bad <= 1'b1;
                    default: ;
                endcase
            end
            if ((w_frame_err || (w_done && !w_ok)) && (r_err_count != 8'hff))
                r_err_count <= r_err_count + 8'd1;
        end
    end

`ifdef MSGDECODE_SEQCHECK_EN
    logic [5:0] r_exp_seq;
    logic       r_seq_seen;
    logic       r_seq_err;

    // Expected sequence: resyncs on every good message; first one is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_seq  <= '0;
            r_seq_seen <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_seq_err <= 1'b0;
            if (w_done && (r_state == TERM)) begin
                r_seq_err <= r_seq_seen && (r_seq != r_exp_seq);
                if (w_ok) begin
                    r_exp_seq  <= r_seq + 6'd1;
                    r_seq_seen <= 1'b1;
                end
            end
        end
    end

    assign io_bus.seq_err = r_seq_err;
`endif

    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_avail = r_out_avail;
    assign io_bus.out_id    = r_id;
    assign io_bus.out_seq   = r_seq;
    assign io_bus.msg_done  = r_msg_done;
    assign io_bus.msg_ok    = r_msg_ok;
    assign io_bus.err_count = r_err_count;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_msgdecode.sv
// Bench for msgdecode: directed frames from the test plan, then randomized
// frames (good, bad CRC, bad terminator, bad seq, garbage) against a
// frame-level reference model. Honors MSGDECODE_SEQCHECK_EN.
module tb_msgdecode;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msgdecode_if bus ();
  msgdecode_pkg::state_t dbg_state;

  msgdecode dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [41:0] exp_word_q[$];   // {id, seq, data}
  logic [9:0]  exp_done_q[$];   // {msg_ok, seq_err, err_count}
  logic [7:0]  tx_q[$];
  logic [31:0] frame_words[256];
  int          m_err = 0;
`ifdef MSGDECODE_SEQCHECK_EN
  logic [5:0]  m_exp_seq = '0;
  bit          m_seen    = 1'b0;
`endif

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic push_done(input bit ok, input bit serr);
    if (!ok) bump_err();
    exp_done_q.push_back({ok, serr, 8'(m_err)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_avail = 1'b1;
    @(posedge clk); #1;
    bus.rx_avail = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_tx(input int gap_pct);
    while (tx_q.size() > 0) begin
      send_byte(tx_q.pop_front());
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
    end
  endtask

  // Builds a whole frame, records the expected words/status, then sends it.
  task automatic send_frame(input logic [3:0] id, input logic [5:0] seq, input int n,
                            input bit bad_crc, input bit bad_term, input int gap_pct);
    logic [15:0] crc;
    logic [7:0]  b;
    bit          ok;
    bit          serr;
    tx_q.delete();
    tx_q.push_back({4'b0110, id});
    tx_q.push_back({2'b00, seq});
    tx_q.push_back(8'(n));
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) tx_q.push_back(frame_words[i][8*k +: 8]);
    crc = 16'h0000;
    foreach (tx_q[j]) begin
      crc = crc ^ {tx_q[j], 8'h00};
      for (int k = 0; k < 8; k++)
        crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
    end
    tx_q.push_back(crc[15:8]);
    b = crc[7:0];
    if (bad_crc) b = b ^ 8'($urandom_range(1, 255));
    tx_q.push_back(b);
    if (bad_term) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h7e);
      tx_q.push_back(b);
      tx_q.push_back(8'h7e);
    end else begin
      tx_q.push_back(8'h7e);
    end
    for (int i = 0; i < n; i++) exp_word_q.push_back({id, seq, frame_words[i]});
    ok   = !bad_crc && !bad_term;
    serr = 1'b0;
`ifdef MSGDECODE_SEQCHECK_EN
    serr = m_seen && (seq != m_exp_seq);
    if (ok) begin
      m_exp_seq = seq + 6'd1;
      m_seen    = 1'b1;
    end
`endif
    push_done(ok, serr);
    send_tx(gap_pct);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_word_q.size() + exp_done_q.size()) != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ((exp_word_q.size() + exp_done_q.size()) != 0) begin
      failures++;
      $display("FAIL drain_%s pending=%0d required=0", tag, exp_word_q.size() + exp_done_q.size());
      exp_word_q.delete();
      exp_done_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_avail"}, 32'(bus.out_avail), 32'd0);
    check_val({tag, "_msg_done"},  32'(bus.msg_done),  32'd0);
    check_val({tag, "_msg_ok"},    32'(bus.msg_ok),    32'd0);
    check_val({tag, "_out_data"},  bus.out_data,       32'd0);
    check_val({tag, "_out_id"},    32'(bus.out_id),    32'd0);
    check_val({tag, "_out_seq"},   32'(bus.out_seq),   32'd0);
    check_val({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    check_val({tag, "_state"},     32'(dbg_state),     32'(msgdecode_pkg::HDR));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_avail) begin
        checks++;
        if (exp_word_q.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected got=%h required=none", {bus.out_id, bus.out_seq, bus.out_data});
        end else begin
          logic [41:0] e;
          e = exp_word_q.pop_front();
          if ({bus.out_id, bus.out_seq, bus.out_data} !== e) begin
            failures++;
            $display("FAIL word got=%h required=%h", {bus.out_id, bus.out_seq, bus.out_data}, e);
          end
        end
      end
      if (bus.msg_done) begin
        logic [9:0] g;
`ifdef MSGDECODE_SEQCHECK_EN
        g = {bus.msg_ok, bus.seq_err, bus.err_count};
`else
        g = {bus.msg_ok, 1'b0, bus.err_count};
`endif
        checks++;
        if (exp_done_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected got=%h required=none", g);
        end else begin
          logic [9:0] e;
          e = exp_done_q.pop_front();
          if (g !== e) begin
            failures++;
            $display("FAIL done ok/seq_err/err got=%h required=%h", g, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] g;
    logic [5:0] s;
    int kind;
    int n;
    bus.rx_data  = 8'h00;
    bus.rx_avail = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Good 1-word frame.
    idle(2);
    frame_words[0] = 32'h44332211;
    send_frame(4'd3, 6'd5, 1, 1'b0, 1'b0, 0);
    // count=0 frame.
    send_frame(4'd0, 6'd0, 0, 1'b0, 1'b0, 30);
    // Corrupt CRC low on a 3-word frame, then a good frame.
    frame_words[0] = 32'hdeadbeef; frame_words[1] = 32'h01020304; frame_words[2] = 32'hcafef00d;
    send_frame(4'd9, 6'd1, 3, 1'b1, 1'b0, 20);
    frame_words[0] = 32'h0badc0de;
    send_frame(4'd9, 6'd2, 1, 1'b0, 1'b0, 0);
    drain("crc");
    check_val("err_after_crc", 32'(bus.err_count), 32'd1);
    // Garbage then resync.
    send_byte(8'h12); bump_err();
    send_byte(8'h7e);
    frame_words[0] = 32'h55aa55aa;
    send_frame(4'd4, 6'd3, 1, 1'b0, 1'b0, 0);
    // Back-to-back frames with idle fill and 0x7e inside data.
    send_byte(8'h7e); send_byte(8'h7e);
    frame_words[0] = 32'h7e7e007e; frame_words[1] = 32'h7e000000;
    send_frame(4'd5, 6'd5, 2, 1'b0, 1'b0, 0);
    send_byte(8'h7e);
    frame_words[0] = 32'h007e7e7e;
    send_frame(4'd6, 6'd7, 1, 1'b0, 1'b0, 0);
    drain("b2b");

    // Reset during DATA1.
    send_byte(8'h65); send_byte(8'h09); send_byte(8'h02); send_byte(8'haa);
    bus.rx_data  = 8'hbb;
    bus.rx_avail = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.rx_avail = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midreset");
    m_err = 0;
`ifdef MSGDECODE_SEQCHECK_EN
    m_seen    = 1'b0;
    m_exp_seq = '0;
`endif
    frame_words[0] = 32'h12345678;
    send_frame(4'd2, 6'd10, 1, 1'b0, 1'b0, 0);
    drain("postreset");

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      n    = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        frame_words[i] = $urandom;
        if ($urandom_range(0, 3) == 0) frame_words[i][15:8] = 8'h7e;
      end
`ifdef MSGDECODE_SEQCHECK_EN
      s = ($urandom_range(0, 4) != 0) ? m_exp_seq : 6'($urandom);
`else
      s = 6'($urandom);
`endif
      case (kind)
        6: send_frame(4'($urandom), s, n, 1'b1, 1'b0, 20);
        7: send_frame(4'($urandom), s, n, 1'b0, 1'b1, 20);
        8: begin
          send_byte({4'b0110, 4'($urandom)});
          send_byte({2'($urandom_range(1, 3)), 6'($urandom)});
          push_done(1'b0, 1'b0);
          send_byte(8'h7e);
        end
        9: begin
          do g = 8'($urandom_range(0, 255)); while (g == 8'h7e || g[7:4] == 4'h6);
          send_byte(g); bump_err();
          send_byte(8'h7e);
        end
        default: send_frame(4'($urandom), s, n, 1'b0, 1'b0, $urandom_range(0, 40));
      endcase
      repeat ($urandom_range(0, 2)) send_byte(8'h7e);
    end
    drain("final");
    check_val("final_err_count", 32'(bus.err_count), 32'(m_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
